// File: rtl/mop_tree_sched.sv
// mop_tree_sched: buffered 8-entry adder-tree reduction over a shared adder.
// Optional cycle counter on cyc_cnt when MOP_TREE_PERF_EN is defined.
module mop_tree_sched #(
  parameter int N = 16,
  parameter int W = N + 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   num_ops,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W:0]   add_sum,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
`ifdef MOP_TREE_PERF_EN
  output logic [7:0]   cyc_cnt,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REDUCE,
    DONE
  } state_t;

  state_t         state_q;
  logic [3:0]     k_q;
  logic [3:0]     idx_q;
  logic [2:0]     step_q;
  logic [W-1:0]   bufr [8];
  logic [2:0]     src_a;
  logic [2:0]     src_b;
  logic [2:0]     dst;
  logic           unused_carry;

  assign unused_carry = add_sum[W];
  assign busy = (state_q != IDLE);

  // Fixed tree schedule: pairs, then quads, then the final merge.
  always_comb begin
    src_a = 3'd0;
    src_b = 3'd1;
    dst   = 3'd0;
    unique case (step_q)
      3'd0: begin src_a = 3'd0; src_b = 3'd1; dst = 3'd0; end
      3'd1: begin src_a = 3'd2; src_b = 3'd3; dst = 3'd2; end
      3'd2: begin src_a = 3'd4; src_b = 3'd5; dst = 3'd4; end
      3'd3: begin src_a = 3'd6; src_b = 3'd7; dst = 3'd6; end
      3'd4: begin src_a = 3'd0; src_b = 3'd2; dst = 3'd0; end
      3'd5: begin src_a = 3'd4; src_b = 3'd6; dst = 3'd4; end
      3'd6: begin src_a = 3'd0; src_b = 3'd4; dst = 3'd0; end
      default: begin src_a = 3'd0; src_b = 3'd1; dst = 3'd0; end
    endcase
  end

  // Shared adder is only driven while reducing; idle elsewhere.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == REDUCE) begin
      add_a = bufr[src_a];
      add_b = bufr[src_b];
    end
  end

  // Control FSM with operand buffer and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      idx_q     <= '0;
      step_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < 8; i++) bufr[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            k_q    <= (num_ops > 4'd8) ? 4'd8 : num_ops;
            idx_q  <= '0;
            step_q <= '0;
            for (int i = 0; i < 8; i++) bufr[i] <= '0;
            if (num_ops == 4'd0) begin
              state_q <= REDUCE;
            end else begin
              state_q  <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            bufr[idx_q[2:0]] <= {{(W-N){1'b0}}, in_data};
            idx_q <= idx_q + 4'd1;
            if (idx_q + 4'd1 == k_q) in_ready <= 1'b0;
          end else if (!in_ready) begin
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          bufr[dst] <= add_sum[W-1:0];
          step_q    <= step_q + 3'd1;
          if (step_q == 3'd6) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
            out_data  <= add_sum[W-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef MOP_TREE_PERF_EN
  // Busy-cycle counter; the cycle entered by start counts as the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (start) cyc_cnt <= 8'd1;
    end else if (cyc_cnt != 8'hFF) begin
      cyc_cnt <= cyc_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mop_tree_sched.sv
// tb_mop_tree_sched: directed checks of the reduction scheduler.
// Models the external adder and checks sums, latency and handshakes.
module tb_mop_tree_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  num_ops;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [18:0] add_a;
  logic [18:0] add_b;
  logic        add_cin;
  logic [19:0] add_sum;
  logic        out_valid;
  logic [18:0] out_data;
  logic        out_ready;
  logic        busy;
`ifdef MOP_TREE_PERF_EN
  logic [7:0]  cyc_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [15:0] ops [8];

  mop_tree_sched #(.N(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_ops(num_ops),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .add_a(add_a),
    .add_b(add_b),
    .add_cin(add_cin),
    .add_sum(add_sum),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
`ifdef MOP_TREE_PERF_EN
    .cyc_cnt(cyc_cnt),
`endif
    .busy(busy)
  );

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {19'd0, add_cin};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] n);
    start = 1'b1;
    num_ops = n;
    tick();
    start = 1'b0;
    num_ops = 4'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    num_ops = 4'd1;
    tick();
    start = 1'b0;
    num_ops = 4'd0;
  endtask

  task automatic feed(input int n, input int max_cyc,
                      output int acc, output int last);
    int i;
    int g;
    logic rdy;
    i = 0;
    g = 0;
    acc = 0;
    last = 0;
    in_valid = 1'b1;
    in_data = ops[0];
    while (i < n && g < max_cyc) begin
      rdy = in_ready;
      tick();
      g++;
      if (rdy) begin
        i++;
        acc++;
        last = cyc;
        if (i < 8) in_data = ops[i];
        else in_data = 16'hFFFF;
      end
    end
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic wait_valid(input int max_cyc, output int at);
    int g;
    g = 0;
    while (!out_valid && g < max_cyc) begin
      tick();
      g++;
    end
    at = cyc;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0h want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0h want 0", out_valid); end
    n_cmp++; if (out_data !== 19'd0) begin n_bad++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
    n_cmp++; if (add_a !== 19'd0 || add_b !== 19'd0 || add_cin !== 1'b0) begin
      n_bad++; $display("FAIL rst_adder: got a=%0h b=%0h c=%0h want 0", add_a, add_b, add_cin);
    end
`ifdef MOP_TREE_PERF_EN
    n_cmp++; if (cyc_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_cyc_cnt: got %0d want 0", cyc_cnt); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full8();
    int acc, last, at;
    for (int i = 0; i < 8; i++) ops[i] = 16'(i + 1);
    start_run(4'd8);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full8_ready: got %0h want 1", in_ready); end
    feed(8, 20, acc, last);
    n_cmp++; if (acc != 8) begin n_bad++; $display("FAIL full8_acc: got %0d want 8", acc); end
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL full8_drain: got rdy=%0h busy=%0h want 0/1", in_ready, busy);
    end
    tick();
    n_cmp++; if (add_a !== 19'd1 || add_b !== 19'd2 || add_cin !== 1'b0) begin
      n_bad++; $display("FAIL full8_step0: got a=%0h b=%0h c=%0h want 1/2/0", add_a, add_b, add_cin);
    end
    wait_valid(20, at);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full8_valid: got %0h want 1", out_valid); end
    n_cmp++; if (at - last != 8) begin n_bad++; $display("FAIL full8_latency: got %0d want 8", at - last); end
    n_cmp++; if (out_data !== 19'd36) begin n_bad++; $display("FAIL full8_sum: got %0d want 36", out_data); end
`ifdef MOP_TREE_PERF_EN
    n_cmp++; if (cyc_cnt !== 8'd17) begin n_bad++; $display("FAIL full8_cyc_cnt: got %0d want 17", cyc_cnt); end
`endif
    drain();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL full8_idle: got ov=%0h busy=%0h want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_three_max();
    int acc, last, at;
    for (int i = 0; i < 8; i++) ops[i] = 16'hFFFF;
    start_run(4'd3);
    feed(3, 20, acc, last);
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL three_acc: got %0d want 3", acc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL three_ready: got %0h want 0", in_ready); end
    wait_valid(20, at);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 19'h2FFFD) begin
      n_bad++; $display("FAIL three_sum: got ov=%0h %0h want 1 2fffd", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_zero_and_clip();
    int acc, last, at, s_at;
    logic seen_rdy;
    start_run(4'd0);
    s_at = cyc;
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL zero_start: got rdy=%0h busy=%0h want 0/1", in_ready, busy);
    end
    seen_rdy = 1'b0;
    for (int g = 0; g < 20 && !out_valid; g++) begin
      if (in_ready) seen_rdy = 1'b1;
      tick();
    end
    at = cyc;
    n_cmp++; if (seen_rdy !== 1'b0) begin n_bad++; $display("FAIL zero_ready: got 1 want 0"); end
    n_cmp++; if (at - s_at != 7) begin n_bad++; $display("FAIL zero_latency: got %0d want 7", at - s_at); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 19'd0) begin
      n_bad++; $display("FAIL zero_sum: got ov=%0h %0h want 1 0", out_valid, out_data);
    end
    drain();
    for (int i = 0; i < 8; i++) ops[i] = 16'(i + 1);
    start_run(4'd12);
    feed(12, 20, acc, last);
    n_cmp++; if (acc != 8) begin n_bad++; $display("FAIL clip_acc: got %0d want 8", acc); end
    wait_valid(20, at);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 19'd36) begin
      n_bad++; $display("FAIL clip_sum: got ov=%0h %0d want 1 36", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_stall_ignore();
    int acc, last, at;
    ops[0] = 16'd3;
    ops[1] = 16'd4;
    start_run(4'd2);
    pulse_start();
    feed(2, 20, acc, last);
    n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL stall_acc: got %0d want 2", acc); end
    tick();
    pulse_start();
    wait_valid(20, at);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 19'd7) begin
        n_bad++; $display("FAIL stall_hold%0d: got ov=%0h %0d want 1 7", i, out_valid, out_data);
      end
    end
    drain();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL stall_idle: got ov=%0h busy=%0h want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int acc, last, at;
    ops[0] = 16'd9;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start_run(4'd1);
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_start: got busy=%0h rdy=%0h want 1/1", busy, in_ready);
    end
    feed(1, 20, acc, last);
    wait_valid(20, at);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 19'd9) begin
      n_bad++; $display("FAIL b2b_sum: got ov=%0h %0d want 1 9", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int acc, last, at;
    logic seen_ov;
    for (int i = 0; i < 8; i++) ops[i] = 16'(i + 1);
    start_run(4'd8);
    feed(8, 20, acc, last);
    tick();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (add_a !== 19'd3 || add_b !== 19'd7) begin
      n_bad++; $display("FAIL mid_step4: got a=%0d b=%0d want 3/7", add_a, add_b);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 19'd0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_out: got ov=%0h od=%0h rdy=%0h busy=%0h want 0",
                        out_valid, out_data, in_ready, busy);
    end
    n_cmp++; if (add_a !== 19'd0 || add_b !== 19'd0 || add_cin !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_add: got a=%0h b=%0h c=%0h want 0", add_a, add_b, add_cin);
    end
`ifdef MOP_TREE_PERF_EN
    n_cmp++; if (cyc_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d want 0", cyc_cnt); end
`endif
    tick();
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || busy) seen_ov = 1'b1;
    end
    n_cmp++; if (seen_ov !== 1'b0) begin n_bad++; $display("FAIL mid_no_out: got 1 want 0"); end
    ops[0] = 16'd5;
    ops[1] = 16'd7;
    start_run(4'd2);
    feed(2, 20, acc, last);
    wait_valid(20, at);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 19'd12) begin
      n_bad++; $display("FAIL mid_rerun: got ov=%0h %0d want 1 12", out_valid, out_data);
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_ops = 4'd0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) ops[i] = '0;
    test_reset();
    test_full8();
    test_three_max();
    test_zero_and_clip();
    test_stall_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mop_tree_sched.md
MOP_TREE_SCHED -- requirements
Module: mop_tree_sched

Interface
REQ-001 SHALL have parameter N, default 16, operand width in bits.
REQ-002 SHALL have parameter W, fixed at N+3, result and shared-adder operand width.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, begins a reduction when sampled high in IDLE.
REQ-006 SHALL have port num_ops, input, 4, operand count latched with start.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, N), in_ready (output, 1): operand handshake.
REQ-008 SHALL have ports add_a (output, W), add_b (output, W), add_cin (output, 1), add_sum (input, W+1): shared external ripple-carry adder, combinational return.
REQ-009 SHALL have ports out_valid (output, 1), out_data (output, W), out_ready (input, 1): result handshake.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> REDUCE -> DONE -> IDLE.
REQ-012 SHALL, in IDLE with start=1, latch K=min(num_ops,8), clear all 8 W-bit buffer entries, and go to LOAD; if K=0, go directly to REDUCE.
REQ-013 SHALL ignore start outside IDLE.
REQ-014 SHALL assert in_ready only in LOAD; on each cycle with in_valid and in_ready, SHALL write zero-extended in_data to buf[idx] and increment idx.
REQ-015 SHALL leave LOAD for REDUCE in the cycle after the K-th operand is accepted; in_ready SHALL be low in that following cycle.
REQ-016 SHALL perform exactly 7 reduce steps, one per cycle, in order: (0,1)->0, (2,3)->2, (4,5)->4, (6,7)->6, (0,2)->0, (4,6)->4, (0,4)->0.
REQ-017 SHALL drive add_a/add_b with the step's source entries and add_cin=0 during REDUCE; outside REDUCE, add_a, add_b, add_cin SHALL be 0.
REQ-018 SHALL write add_sum[W-1:0] to the step's destination entry at the end of each step; add_sum[W] is always 0 for valid operands and SHALL be ignored.
REQ-019 SHALL, after step 7, enter DONE with out_valid=1 and out_data=buf[0], both held stable until out_ready=1.
REQ-020 SHALL return to IDLE in the cycle after out_valid and out_ready are both high; out_valid SHALL then be 0.
REQ-021 SHALL produce out_data equal to the unsigned sum of the K accepted operands, with unused entries contributing 0.
REQ-022 SHALL give a fixed latency of 8 cycles from the last operand acceptance to out_valid rising.
REQ-023 SHALL accept a start in the cycle immediately after returning to IDLE.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, idx 0, buffer all 0, in_ready 0, out_valid 0, out_data 0, busy 0, and add_a/add_b/add_cin 0.
REQ-025 SHALL, on reset mid-LOAD or mid-REDUCE, discard the partial reduction with no output produced.

Configuration
REQ-026 SHALL, with MOP_TREE_PERF_EN defined, add output cyc_cnt (8 bits), cleared at start, incremented each busy cycle, saturating at 255, and held through IDLE until the next start; reset value 0.
REQ-027 SHALL, without MOP_TREE_PERF_EN, have no cyc_cnt port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-028 start, num_ops=8, operands 1..8 back-to-back -> out_data=36, out_valid 8 cycles after the 8th acceptance.
REQ-029 num_ops=3, operands 0xFFFF x3 -> out_data=0x2FFFD; in_ready low after the 3rd acceptance.
REQ-030 num_ops=0 -> no in_ready; out_data=0 after 7 REDUCE cycles; num_ops=12 -> exactly 8 operands accepted.
REQ-031 out_ready held low 5 cycles in DONE -> out_valid/out_data stable; start pulses in LOAD, REDUCE, and DONE are ignored.
REQ-032 rst_n asserted at REDUCE step 4 -> all outputs 0 immediately; a new run of 2 operands 5 and 7 -> out_data=12.
REQ-033 With MOP_TREE_PERF_EN, an 8-operand run with no stalls -> cyc_cnt=17 when out_valid rises.
